seg_red_unit: RTL and testbench
===============================

# seg_red_unit

Parametrised, pipelined segmented reduction unit: the successor to the PE's single-row adder tree. It accepts one N-lane product vector per cycle, partitions it into contiguous row segments marked by `split` flags, and forms a segmented inclusive prefix sum across the lanes. It then routes the selected lane sums to N output lanes through `out_idx`. It sits between the PE multiplier row and the SpMM output buffer, and lets one vector carry several CSR rows.

## Interface
- `N`, 16: lane count; power of two, N ≥ 2.
- `W`, 8: data width in bits; sums are unsigned.
- `SAT`, 0: overflow mode. 0 wraps mod 2^W; 1 saturates at 2^W−1.
- `LGN`, $clog2(N): derived; do not override.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all pipeline state.
- `en`  in  1  pipeline advance. 0 freezes every stage, including `out_valid`.
- `in_valid`  in  1  input vector valid this cycle.
- `data`  in  N×W  lane products.
- `split`  in  N×1  `split[i]`=1 means lane i ends a segment.
- `out_idx`  in  N×LGN  `out_data[k]` takes the prefix sum of lane `out_idx[k]`.
- `out_valid`  out  1  `out_data` holds a result.
- `out_data`  out  N×W  routed segment sums.
- `delay`  out  int  constant LGN+1.
- `num_el`  out  int  constant N.

## Operation
- Head flags: `head[0]`=1; `head[i]`=`split[i-1]` for i>0. `split[N-1]` is ignored, because lane N-1 always closes the vector.
- Scan uses a Kogge-Stone network with LGN stages. In stage s, with d=2^s, for each i≥d where `head[i]`=0:
  - `val[i]` ← `val[i]` ⊕ `val[i-d]`
  - `head[i]` ← `head[i]` | `head[i-d]`
  - Lanes with i<d, or with `head[i]`=1, pass through unchanged.
- ⊕ is W-bit wrap when SAT=0. When SAT=1 it is a saturating unsigned add: compute the W+1-bit sum and clamp to 2^W−1. Saturating add is associative, so scan order does not change the result.
- After the scan, lane i holds the sum of its own segment from the segment start through lane i. Lane i is the segment total only when it is a segment's last lane.
- Output stage: `out_data[k]` = `scan[out_idx[k]]`, registered. Lane selection has no restriction: any lane can be selected, and one lane can be selected by several outputs.
- `out_idx` and `in_valid` travel down the pipeline alongside the data, LGN+1 registers deep.
- Data registers load on every cycle with `en`=1, whatever `in_valid` is. Downstream consumers qualify results with `out_valid` only.

## Timing
- Latency is LGN+1 enabled cycles, from an `in_valid`=1 sample to `out_valid`=1 with the matching `out_data`.
- Throughput is one vector per enabled cycle. Back-to-back vectors are never mixed.
- `en`=0 holds all stages and outputs stable. A vector's latency counts only cycles with `en`=1.
- Reset, whenever asserted, including mid-stream:
  - `out_valid`=0 and `out_data`=0 immediately.
  - All stage valid bits clear, and in-flight vectors are discarded.
  - The first vector accepted after reset deassertion appears LGN+1 enabled cycles later.
- `reset` and `en` asserted together: reset wins.
- The scan path is fully synchronous. No combinational path runs from the inputs to `out_data` or `out_valid`.

## Structure
- `data_t`, `N`, `W` and `lgN` belong in the shared `spmm_pkg`. The `SAT` encoding constants also belong there.
- Sub-module `seg_scan_stage #(N, W, SAT, DIST)`: one registered Kogge-Stone step.
  - Carries val, head, out_idx and valid.
  - Instantiated LGN times in a generate loop, with DIST=2^s.
- Output crossbar and register live in the top module.

## Test plan
Directed scenarios use N=4, W=8 unless noted.
- Two segments: data=[1,2,3,4], split=[0,1,0,1], out_idx=[1,3,0,0], SAT=0 → `out_data`=[3,7,1,1], `out_valid` exactly 3 cycles after input.
- One row: data=[10,20,30,40], split all 0, out_idx all 3 → every lane 100. Repeat at N=16 with data=i+1 and out_idx all 15 → 136, `delay`=5.
- Overflow: data all 100, split all 0, out_idx all 3 → 144 with SAT=0, 255 with SAT=1.
- Every split=1, out_idx=[3,2,1,0], data=[5,6,7,8] → [8,7,6,5]: each lane is its own segment.
- Streaming with stalls: five consecutive vectors with `en` low on cycles 2 and 4 → results emerge in order, and each is held unchanged while `en`=0.
- Reset on the cycle after three vectors enter → `out_valid`=0 and `out_data`=0 at once. No stale result appears. A fresh vector sent after reset returns correctly after LGN+1 cycles.

Source files
------------

// File: rtl/spmm_pkg.sv
// ----------------------------------------------------------------------------
// spmm_pkg: shared constants and types for the SpMM datapath.
//   N, W, lgN  - default lane count, data width and log2(lane count)
//   data_t     - one lane product / sum at the default width
//   SAT_WRAP   - overflow mode: wrap modulo 2^W
//   SAT_CLAMP  - overflow mode: saturate at 2^W-1
// ----------------------------------------------------------------------------
package spmm_pkg;

    localparam int N   = 16;
    localparam int W   = 8;
    localparam int lgN = $clog2(N);

    typedef logic [W-1:0] data_t;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

endpackage

// File: rtl/seg_scan_stage.sv
// ----------------------------------------------------------------------------
// seg_scan_stage: one registered Kogge-Stone step of the segmented scan.
// A lane that is not a segment head absorbs the value DIST lanes below it and
// inherits that lane's head flag; heads and the lowest DIST lanes pass through.
//   clock, reset          - rising-edge clock, async active-high reset
//   en                    - stage advance; 0 holds every register
//   in_valid / out_valid  - vector valid, travels with the data
//   in_val / out_val      - N lane partial sums
//   in_head / out_head    - N lane segment-head flags
//   in_idx / out_idx      - output routing indices, carried unchanged
// ----------------------------------------------------------------------------
module seg_scan_stage #(
    parameter int N    = 16,
    parameter int W    = 8,
    parameter int SAT  = 0,
    parameter int DIST = 1,
    parameter int LGN  = $clog2(N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [N-1:0][W-1:0]     in_val,
    input  logic [N-1:0]            in_head,
    input  logic [N-1:0][LGN-1:0]   in_idx,
    output logic                    out_valid,
    output logic [N-1:0][W-1:0]     out_val,
    output logic [N-1:0]            out_head,
    output logic [N-1:0][LGN-1:0]   out_idx
);
    import spmm_pkg::*;

    // Saturating add stays associative, so the scan order is irrelevant.
    function automatic logic [W-1:0] seg_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT == SAT_CLAMP && s[W])
            return '1;
        return s[W-1:0];
    endfunction

    logic [N-1:0][W-1:0] nxt_val;
    logic [N-1:0]        nxt_head;

    always_comb begin
        nxt_val  = in_val;
        nxt_head = in_head;
        for (int i = DIST; i < N; i++) begin
            if (!in_head[i]) begin
                nxt_val[i]  = seg_add(in_val[i], in_val[i-DIST]);
                // head[i] is 0 here, so the OR reduces to the lower flag
                nxt_head[i] = in_head[i-DIST];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_head  <= '0;
            out_idx   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_val   <= nxt_val;
            out_head  <= nxt_head;
            out_idx   <= in_idx;
        end
    end

endmodule

// File: rtl/seg_red_unit.sv
// ----------------------------------------------------------------------------
// seg_red_unit: pipelined segmented reduction. Each N-lane vector is split
// into row segments by `split`, scanned with an LGN-stage Kogge-Stone
// network, then routed to N outputs through `out_idx`. Latency LGN+1.
//   clock, reset - rising-edge clock, async active-high reset
//   en           - pipeline advance; 0 freezes every stage and the outputs
//   in_valid     - input vector valid
//   data         - N x W lane products
//   split        - split[i]=1: lane i ends a segment (split[N-1] ignored)
//   out_idx      - out_data[k] takes the prefix sum of lane out_idx[k]
//   out_valid    - out_data holds a result
//   out_data     - N x W routed segment sums
//   delay        - constant LGN+1
//   num_el       - constant N
// ----------------------------------------------------------------------------
module seg_red_unit #(
    parameter int N   = spmm_pkg::N,
    parameter int W   = spmm_pkg::W,
    parameter int SAT = spmm_pkg::SAT_WRAP,
    parameter int LGN = $clog2(N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [N-1:0][W-1:0]     data,
    input  logic [N-1:0]            split,
    input  logic [N-1:0][LGN-1:0]   out_idx,
    output logic                    out_valid,
    output logic [N-1:0][W-1:0]     out_data,
    output int                      delay,
    output int                      num_el
);
    import spmm_pkg::*;

    // Index s is the input of scan stage s; index LGN is the scan result.
    logic [LGN:0]                     vld_pipe;
    logic [LGN:0][N-1:0][W-1:0]       stg_val;
    logic [LGN:0][N-1:0]              stg_head;
    logic [LGN:0][N-1:0][LGN-1:0]     stg_idx;

    // Lane 0 always opens a segment; a lane opens one when its lower
    // neighbour closed the previous one.
    assign vld_pipe[0] = in_valid;
    assign stg_val[0]  = data;
    assign stg_head[0] = {split[N-2:0], 1'b1};
    assign stg_idx[0]  = out_idx;

    genvar s;
    generate
        for (s = 0; s < LGN; s++) begin : g_stage
            seg_scan_stage #(
                .N    (N),
                .W    (W),
                .SAT  (SAT),
                .DIST (1 << s),
                .LGN  (LGN)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .en        (en),
                .in_valid  (vld_pipe[s]),
                .in_val    (stg_val[s]),
                .in_head   (stg_head[s]),
                .in_idx    (stg_idx[s]),
                .out_valid (vld_pipe[s+1]),
                .out_val   (stg_val[s+1]),
                .out_head  (stg_head[s+1]),
                .out_idx   (stg_idx[s+1])
            );
        end
    endgenerate

    // Head flags after the last stage have no consumer.
    logic unused_head;
    assign unused_head = ^stg_head[LGN];

    // Output crossbar: any lane may feed any number of outputs.
    logic [N-1:0][W-1:0] xbar;

    always_comb begin
        xbar = '0;
        for (int k = 0; k < N; k++)
            xbar[k] = stg_val[LGN][stg_idx[LGN][k]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= vld_pipe[LGN];
            out_data  <= xbar;
        end
    end

    assign delay  = LGN + 1;
    assign num_el = N;

endmodule

// File: tb/tb_seg_red_unit.sv
module tb_seg_red_unit;

    logic clock = 1'b0;
    logic reset, en;
    int   errors, checks;

    always #5 clock = ~clock;

    // N=4 wrap and N=4 saturating units share one stimulus set
    logic                v4;
    logic [3:0][7:0]     d4;
    logic [3:0]          s4;
    logic [3:0][1:0]     i4;
    logic                ov4, ov4s;
    logic [3:0][7:0]     od4, od4s;
    int                  dl4, ne4, dl4s, ne4s;

    logic                v16;
    logic [15:0][7:0]    d16;
    logic [15:0]         s16;
    logic [15:0][3:0]    i16;
    logic                ov16;
    logic [15:0][7:0]    od16;
    int                  dl16, ne16;

    seg_red_unit #(.N(4), .W(8), .SAT(0)) u4 (
        .clock(clock), .reset(reset), .en(en), .in_valid(v4), .data(d4),
        .split(s4), .out_idx(i4), .out_valid(ov4), .out_data(od4),
        .delay(dl4), .num_el(ne4));

    seg_red_unit #(.N(4), .W(8), .SAT(1)) u4s (
        .clock(clock), .reset(reset), .en(en), .in_valid(v4), .data(d4),
        .split(s4), .out_idx(i4), .out_valid(ov4s), .out_data(od4s),
        .delay(dl4s), .num_el(ne4s));

    seg_red_unit #(.N(16), .W(8), .SAT(0)) u16 (
        .clock(clock), .reset(reset), .en(en), .in_valid(v16), .data(d16),
        .split(s16), .out_idx(i16), .out_valid(ov16), .out_data(od16),
        .delay(dl16), .num_el(ne16));

    // Reference: walk down from lane j to its segment start, summing.
    function automatic logic [7:0] ref_lane(input logic [15:0][7:0] d,
                                            input logic [15:0] sp,
                                            input int j, input bit sat);
        int total;
        int m;
        m = j;
        total = int'(d[m]);
        while (m > 0 && !sp[m-1]) begin
            m--;
            total += int'(d[m]);
        end
        if (sat) return (total > 255) ? 8'd255 : 8'(total);
        return 8'(total % 256);
    endfunction

    task automatic step;
        @(posedge clock); #1;
    endtask

    task automatic flush;
        v4 = 1'b0; v16 = 1'b0; en = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; v4 = 1'b1; v16 = 1'b1;
        #1;
        checks++;
        if (ov4 !== 1'b0 || od4 !== '0 || ov4s !== 1'b0 || od4s !== '0 || ov16 !== 1'b0 || od16 !== '0) begin
            errors++;
            $display("FAIL reset_state: got v4=%b d4=%h v16=%b d16=%h, want zeros", ov4, od4, ov16, od16);
        end
        checks++;
        if (dl4 != 3 || ne4 != 4 || dl16 != 5 || ne16 != 16) begin
            errors++;
            $display("FAIL constants: got delay4=%0d num4=%0d delay16=%0d num16=%0d, want 3 4 5 16", dl4, ne4, dl16, ne16);
        end
        // reset beats en with in_valid held high
        repeat (4) step();
        checks++;
        if (ov4 !== 1'b0 || ov16 !== 1'b0 || od4 !== '0) begin
            errors++;
            $display("FAIL reset_over_en: got v4=%b v16=%b d4=%h, want 0 0 0", ov4, ov16, od4);
        end
        v4 = 1'b0; v16 = 1'b0;
        reset = 1'b0;
        flush();
    endtask

    task automatic test_two_segments;
        d4 = {8'd4, 8'd3, 8'd2, 8'd1};
        s4 = 4'b1010;
        i4 = {2'd0, 2'd0, 2'd3, 2'd1};
        v4 = 1'b1; step(); v4 = 1'b0;
        step();
        checks++;
        if (ov4 !== 1'b0) begin
            errors++;
            $display("FAIL two_seg_early: out_valid=%b after 2 cycles, want 0", ov4);
        end
        step();
        checks++;
        if (ov4 !== 1'b1 || od4 !== {8'd1, 8'd1, 8'd7, 8'd3}) begin
            errors++;
            $display("FAIL two_seg: got v=%b data=%h, want v=1 data=01010703", ov4, od4);
        end
        step();
        checks++;
        if (ov4 !== 1'b0) begin
            errors++;
            $display("FAIL two_seg_after: out_valid=%b, want 0", ov4);
        end
        flush();
    endtask

    task automatic test_one_row;
        d4 = {8'd40, 8'd30, 8'd20, 8'd10};
        s4 = 4'b0000;
        i4 = {4{2'd3}};
        for (int l = 0; l < 16; l++) d16[l] = 8'(l + 1);
        s16 = '0;
        i16 = {16{4'd15}};
        v4 = 1'b1; v16 = 1'b1; step(); v4 = 1'b0; v16 = 1'b0;
        step(); step();
        checks++;
        if (ov4 !== 1'b1 || od4 !== {4{8'd100}}) begin
            errors++;
            $display("FAIL one_row_n4: got v=%b data=%h, want v=1 data=64646464", ov4, od4);
        end
        step();
        checks++;
        if (ov16 !== 1'b0) begin
            errors++;
            $display("FAIL one_row_n16_early: out_valid=%b after 4 cycles, want 0", ov16);
        end
        step();
        checks++;
        if (ov16 !== 1'b1 || od16 !== {16{8'd136}}) begin
            errors++;
            $display("FAIL one_row_n16: got v=%b data=%h, want v=1 all 88", ov16, od16);
        end
        flush();
    endtask

    task automatic test_overflow;
        d4 = {4{8'd100}};
        s4 = 4'b0000;
        i4 = {4{2'd3}};
        v4 = 1'b1; step(); v4 = 1'b0;
        step(); step();
        checks++;
        if (ov4 !== 1'b1 || od4 !== {4{8'd144}}) begin
            errors++;
            $display("FAIL overflow_wrap: got v=%b data=%h, want v=1 all 90", ov4, od4);
        end
        checks++;
        if (ov4s !== 1'b1 || od4s !== {4{8'd255}}) begin
            errors++;
            $display("FAIL overflow_sat: got v=%b data=%h, want v=1 all ff", ov4s, od4s);
        end
        flush();
    endtask

    task automatic test_all_split;
        d4 = {8'd8, 8'd7, 8'd6, 8'd5};
        s4 = 4'b1111;
        i4 = {2'd0, 2'd1, 2'd2, 2'd3};
        v4 = 1'b1; step(); v4 = 1'b0;
        step(); step();
        checks++;
        if (ov4 !== 1'b1 || od4 !== {8'd5, 8'd6, 8'd7, 8'd8}) begin
            errors++;
            $display("FAIL all_split: got v=%b data=%h, want v=1 data=05060708", ov4, od4);
        end
        flush();
    endtask

    // Stream nvec random vectors through all three units. stall_mode drops
    // en on cycles 2 and 4; otherwise en is random while vectors remain.
    task automatic test_stream(input int nvec, input bit stall_mode);
        logic [3:0][7:0]  vd4[64];
        logic [3:0]       vs4[64];
        logic [3:0][1:0]  vi4[64];
        logic [15:0][7:0] vd16[64];
        logic [15:0]      vs16[64];
        logic [15:0][3:0] vi16[64];
        logic [3:0][7:0]  x4[64];
        logic [3:0][7:0]  x4s[64];
        logic [15:0][7:0] x16[64];
        int               acc[64];
        logic [15:0][7:0] wd;
        logic [15:0]      ws;
        int               sent, ec, seen4, seen16, k4, k16;
        logic [3:0][7:0]  p4;
        logic [15:0][7:0] p16;
        logic             p4v, p16v;

        for (int k = 0; k < nvec; k++) begin
            for (int l = 0; l < 16; l++) begin
                vd16[k][l] = 8'($urandom);
                vi16[k][l] = 4'($urandom);
            end
            vs16[k] = 16'($urandom);
            for (int l = 0; l < 4; l++) begin
                vd4[k][l] = 8'($urandom_range(0, 255));
                vi4[k][l] = 2'($urandom);
            end
            vs4[k] = 4'($urandom);
            wd = '0; ws = '0;
            wd[3:0] = vd4[k];
            ws[3:0] = vs4[k];
            for (int l = 0; l < 4; l++) begin
                x4[k][l]  = ref_lane(wd, ws, int'(vi4[k][l]), 1'b0);
                x4s[k][l] = ref_lane(wd, ws, int'(vi4[k][l]), 1'b1);
            end
            for (int l = 0; l < 16; l++)
                x16[k][l] = ref_lane(vd16[k], vs16[k], int'(vi16[k][l]), 1'b0);
            acc[k] = -100;
        end

        sent = 0; ec = 0; seen4 = 0; seen16 = 0;
        p4 = od4; p4v = ov4; p16 = od16; p16v = ov16;
        for (int cyc = 0; cyc < nvec + 40; cyc++) begin
            if (sent < nvec) begin
                en  = stall_mode ? !(cyc == 2 || cyc == 4) : ($urandom_range(0, 3) != 0);
                v4  = 1'b1; d4  = vd4[sent];  s4  = vs4[sent];  i4  = vi4[sent];
                v16 = 1'b1; d16 = vd16[sent]; s16 = vs16[sent]; i16 = vi16[sent];
            end else begin
                en = 1'b1; v4 = 1'b0; v16 = 1'b0;
            end
            step();
            if (en) begin
                ec++;
                if (v4) begin
                    acc[sent] = ec;
                    sent++;
                end
            end
            if (!en) begin
                checks++;
                if (ov4 !== p4v || od4 !== p4 || ov16 !== p16v || od16 !== p16) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: got v4=%b d4=%h v16=%b, want v4=%b d4=%h v16=%b",
                             cyc, ov4, od4, ov16, p4v, p4, p16v);
                end
            end else begin
                k4 = -1; k16 = -1;
                for (int k = 0; k < nvec; k++) begin
                    if (acc[k] == ec - 2) k4 = k;
                    if (acc[k] == ec - 4) k16 = k;
                end
                checks++;
                if (k4 >= 0) begin
                    if (ov4 !== 1'b1 || od4 !== x4[k4] || ov4s !== 1'b1 || od4s !== x4s[k4]) begin
                        errors++;
                        $display("FAIL stream_n4 vec=%0d: got v=%b d=%h sat v=%b d=%h, want v=1 d=%h sat d=%h",
                                 k4, ov4, od4, ov4s, od4s, x4[k4], x4s[k4]);
                    end else seen4++;
                end else if (ov4 !== 1'b0 || ov4s !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_n4_idle cyc=%0d: got v=%b sat v=%b, want 0", cyc, ov4, ov4s);
                end
                checks++;
                if (k16 >= 0) begin
                    if (ov16 !== 1'b1 || od16 !== x16[k16]) begin
                        errors++;
                        $display("FAIL stream_n16 vec=%0d: got v=%b d=%h, want v=1 d=%h", k16, ov16, od16, x16[k16]);
                    end else seen16++;
                end else if (ov16 !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_n16_idle cyc=%0d: got v=%b, want 0", cyc, ov16);
                end
            end
            p4 = od4; p4v = ov4; p16 = od16; p16v = ov16;
        end
        checks++;
        if (seen4 != nvec || seen16 != nvec) begin
            errors++;
            $display("FAIL stream_count: got n4=%0d n16=%0d, want %0d", seen4, seen16, nvec);
        end
        flush();
    endtask

    task automatic test_reset_midstream;
        logic [15:0][7:0] wd;
        logic [15:0]      ws;
        logic [3:0][7:0]  exp4;
        en = 1'b1;
        s4 = 4'b0000; i4 = {4{2'd3}};
        v4 = 1'b1; v16 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d4 = {4{8'(k + 1)}};
            for (int l = 0; l < 16; l++) d16[l] = 8'(k + l);
            step();
        end
        v4 = 1'b0; v16 = 1'b0;
        checks++;
        if (ov4 !== 1'b1 || od4 !== {4{8'd4}}) begin
            errors++;
            $display("FAIL pre_reset: got v=%b d=%h, want v=1 all 04", ov4, od4);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ov4 !== 1'b0 || od4 !== '0 || ov4s !== 1'b0 || od4s !== '0 || ov16 !== 1'b0 || od16 !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v4=%b d4=%h v16=%b d16=%h, want zeros", ov4, od4, ov16, od16);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (ov4 !== 1'b0 || ov4s !== 1'b0 || ov16 !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset c=%0d: got v4=%b v16=%b, want 0", c, ov4, ov16);
            end
        end
        d4 = {8'd9, 8'd250, 8'd3, 8'd7};
        s4 = 4'b0001;
        i4 = {2'd3, 2'd2, 2'd1, 2'd0};
        wd = '0; ws = '0;
        wd[3:0] = d4; ws[3:0] = s4;
        for (int l = 0; l < 4; l++) exp4[l] = ref_lane(wd, ws, int'(i4[l]), 1'b0);
        v4 = 1'b1; step(); v4 = 1'b0;
        step(); step();
        checks++;
        if (ov4 !== 1'b1 || od4 !== exp4) begin
            errors++;
            $display("FAIL fresh_after_reset: got v=%b d=%h, want v=1 d=%h", ov4, od4, exp4);
        end
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; en = 1'b0;
        v4 = 1'b0; d4 = '0; s4 = '0; i4 = '0;
        v16 = 1'b0; d16 = '0; s16 = '0; i16 = '0;
        test_reset();
        test_two_segments();
        test_one_row();
        test_overflow();
        test_all_split();
        test_stream(5, 1'b1);
        test_stream(40, 1'b0);
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
